// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_if
//  Description : Control/handshake bundle between the multi-cycle sequencer
//                (master) and the memory port / datapath (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_controller_if #(
   parameter int CNT_WIDTH = 32
);
   // Memory port and datapath status into the sequencer
   logic [31:0]          instr_rdata;
   logic                 mem_ready;
   logic                 zero;
   // Phase enables and mux selects out of the sequencer
   logic                 pc_write;
   logic [1:0]           pc_src;
   logic                 ir_write;
   logic                 mem_read;
   logic                 mem_write;
   logic                 reg_write;
   logic                 reg_dst;
   logic                 alu_src;
   logic                 mem_to_reg;
   logic [2:0]           alu_op;
   logic                 instr_done;
   logic                 illegal_op;
   logic [2:0]           state;
   logic [CNT_WIDTH-1:0] retired_cnt;
   logic [CNT_WIDTH-1:0] stall_cnt;

   modport master (
      input  instr_rdata, mem_ready, zero,
      output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
             reg_dst, alu_src, mem_to_reg, alu_op, instr_done, illegal_op,
             state, retired_cnt, stall_cnt
   );

   modport slave (
      output instr_rdata, mem_ready, zero,
      input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
             reg_dst, alu_src, mem_to_reg, alu_op, instr_done, illegal_op,
             state, retired_cnt, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore sequencer stepping each RISCY instruction through
//                FETCH/DECODE/EXEC/MEM/WB with memory-ready stalls.
//                Optional performance counters: define CTRL_PERF_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller #(
   parameter int CNT_WIDTH = 32
) (
   input  wire logic               clk,
   input  wire logic               reset,
   multicycle_controller_if.master bus
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_ADDI  = 6'b010000;
   localparam logic [5:0] c_OP_ANDI  = 6'b010001;
   localparam logic [5:0] c_OP_XORI  = 6'b010010;
   localparam logic [5:0] c_OP_BEQ   = 6'b010011;
   localparam logic [5:0] c_OP_LW    = 6'b010101;
   localparam logic [5:0] c_OP_SW    = 6'b010110;
   localparam logic [5:0] c_OP_SLT   = 6'b010111;
   localparam logic [5:0] c_OP_SLTI  = 6'b011000;
   localparam logic [5:0] c_OP_J     = 6'b011001;

   state_t     state_q, state_d;
   logic [5:0] opcode_q;

   logic       w_legal, w_imm, w_rd_sel, w_is_j, w_is_beq, w_is_lw, w_is_sw;
   logic [2:0] w_class_aluop;

   logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
   logic       w_reg_dst, w_alu_src, w_mem_to_reg, w_instr_done, w_illegal_op;
   logic [1:0] w_pc_src;
   logic [2:0] w_alu_op;

   // Only the opcode field of the fetched word matters to sequencing
   logic       w_unused_rdata;
   assign w_unused_rdata = ^bus.instr_rdata[25:0];

   // Classify the latched opcode: ALU op, immediate operand, rd select
   always_comb begin
      w_legal       = 1'b1;
      w_imm         = 1'b0;
      w_rd_sel      = 1'b0;
      w_class_aluop = 3'b000;
      w_is_j        = (opcode_q == c_OP_J);
      w_is_beq      = (opcode_q == c_OP_BEQ);
      w_is_lw       = (opcode_q == c_OP_LW);
      w_is_sw       = (opcode_q == c_OP_SW);
      case (opcode_q)
         c_OP_RTYPE,
         c_OP_SLT:  begin w_class_aluop = 3'b010; w_rd_sel = 1'b1; end
         c_OP_ADDI: begin w_class_aluop = 3'b011; w_imm = 1'b1; end
         c_OP_ANDI: begin w_class_aluop = 3'b100; w_imm = 1'b1; end
         c_OP_XORI: begin w_class_aluop = 3'b101; w_imm = 1'b1; end
         c_OP_SLTI: begin w_class_aluop = 3'b110; w_imm = 1'b1; end
         c_OP_BEQ:  w_class_aluop = 3'b001;
         c_OP_LW,
         c_OP_SW:   begin w_class_aluop = 3'b000; w_imm = 1'b1; end
         c_OP_J:    w_class_aluop = 3'b111;
         default:   w_legal = 1'b0;
      endcase
   end

   // State register; reset parks the sequencer in INIT
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   // Opcode latch loads alongside the instruction register
   always_ff @(posedge clk) begin
      if (reset)           opcode_q <= 6'b000000;
      else if (w_ir_write) opcode_q <= bus.instr_rdata[31:26];
   end

   // Next-state and per-phase enables; everything idles at 0 unless driven
   always_comb begin
      state_d      = state_q;
      w_pc_write   = 1'b0;
      w_pc_src     = 2'b00;
      w_ir_write   = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_alu_src    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_alu_op     = 3'b000;
      w_instr_done = 1'b0;
      w_illegal_op = 1'b0;
      case (state_q)
         S_INIT: state_d = S_FETCH;
         S_FETCH: begin
            w_mem_read = 1'b1;
            if (bus.mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_is_j) begin
               w_pc_write   = 1'b1;
               w_pc_src     = 2'b10;
               w_instr_done = 1'b1;
               state_d      = S_FETCH;
            end else if (!w_legal) begin
               // PC already advanced in FETCH; just drop the word
               w_illegal_op = 1'b1;
               state_d      = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            w_alu_op  = w_class_aluop;
            w_alu_src = w_imm;
            if (w_is_beq) begin
               w_pc_write   = bus.zero;
               w_pc_src     = 2'b01;
               w_instr_done = 1'b1;
               state_d      = S_FETCH;
            end else if (w_is_lw || w_is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (w_is_lw) begin
               w_mem_read = 1'b1;
               if (bus.mem_ready) state_d = S_WB;
            end else begin
               w_mem_write = 1'b1;
               if (bus.mem_ready) begin
                  w_instr_done = 1'b1;
                  state_d      = S_FETCH;
               end
            end
         end
         S_WB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = w_rd_sel;
            w_mem_to_reg = w_is_lw;
            w_alu_op     = w_class_aluop;
            w_instr_done = 1'b1;
            state_d      = S_FETCH;
         end
         default: state_d = S_INIT;
      endcase
   end

   assign bus.pc_write   = w_pc_write;
   assign bus.pc_src     = w_pc_src;
   assign bus.ir_write   = w_ir_write;
   assign bus.mem_read   = w_mem_read;
   assign bus.mem_write  = w_mem_write;
   assign bus.reg_write  = w_reg_write;
   assign bus.reg_dst    = w_reg_dst;
   assign bus.alu_src    = w_alu_src;
   assign bus.mem_to_reg = w_mem_to_reg;
   assign bus.alu_op     = w_alu_op;
   assign bus.instr_done = w_instr_done;
   assign bus.illegal_op = w_illegal_op;
   assign bus.state      = state_q;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] retired_q, stall_q;
   logic                 w_stall;
   assign w_stall = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;

   // Free-running retire and memory-stall counters, wrapping naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (w_instr_done) retired_q <= retired_q + 1'b1;
         if (w_stall)      stall_q   <= stall_q + 1'b1;
      end
   end
   assign bus.retired_cnt = retired_q;
   assign bus.stall_cnt   = stall_q;
`else
   assign bus.retired_cnt = {CNT_WIDTH{1'b0}};
   assign bus.stall_cnt   = {CNT_WIDTH{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller: directed
//                scenarios followed by random instruction streams compared
//                against a phase-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

   localparam int CNT_WIDTH = 32;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b010000;
   localparam logic [5:0] OP_ANDI = 6'b010001;
   localparam logic [5:0] OP_XORI = 6'b010010;
   localparam logic [5:0] OP_BEQ  = 6'b010011;
   localparam logic [5:0] OP_ILL  = 6'b010100;
   localparam logic [5:0] OP_LW   = 6'b010101;
   localparam logic [5:0] OP_SW   = 6'b010110;
   localparam logic [5:0] OP_SLT  = 6'b010111;
   localparam logic [5:0] OP_SLTI = 6'b011000;
   localparam logic [5:0] OP_J    = 6'b011001;

   logic clk;
   logic reset;
   int   chk_count;
   int   fail_count;
   int   ret_m;
   int   stall_m;

   multicycle_controller_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

   multicycle_controller #(.CNT_WIDTH(CNT_WIDTH)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected control vector, field order matches the packing in cyc()
   function automatic logic [14:0] mk(input logic pcw, input logic [1:0] pcs,
                                      input logic irw, input logic mr, input logic mw,
                                      input logic rw, input logic rd, input logic as,
                                      input logic m2r, input logic [2:0] aop,
                                      input logic done, input logic ill);
      return {pcw, pcs, irw, mr, mw, rw, rd, as, m2r, aop, done, ill};
   endfunction

   // One clock: apply inputs, check Moore outputs and counters, account model
   task automatic cyc(input logic [2:0] est, input logic [14:0] ectl,
                      input logic rdy, input logic z, input logic [31:0] rdata);
      logic [14:0] obs;
      @(negedge clk);
      bus.mem_ready   = rdy;
      bus.zero        = z;
      bus.instr_rdata = rdata;
      #1;
      obs = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
             bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.alu_op,
             bus.instr_done, bus.illegal_op};
      check("state", {29'd0, bus.state}, {29'd0, est});
      check("ctl", {17'd0, obs}, {17'd0, ectl});
`ifdef CTRL_PERF_CNT_EN
      check("retired_cnt", bus.retired_cnt, ret_m);
      check("stall_cnt", bus.stall_cnt, stall_m);
`else
      check("retired_cnt", bus.retired_cnt, 32'd0);
      check("stall_cnt", bus.stall_cnt, 32'd0);
`endif
      if (ectl[1]) ret_m++;
      if ((est == 3'd1 || est == 3'd4) && !rdy) stall_m++;
   endtask

   // Hold reset for n edges, release, confirm one silent INIT cycle
   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      ret_m   = 0;
      stall_m = 0;
      #1;
      check("rst_state", {29'd0, bus.state}, 32'd0);
      check("rst_ctl", {17'd0, bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read,
                        bus.mem_write, bus.reg_write, bus.reg_dst, bus.alu_src,
                        bus.mem_to_reg, bus.alu_op, bus.instr_done, bus.illegal_op}, 32'd0);
      check("rst_retired", bus.retired_cnt, 32'd0);
      check("rst_stall", bus.stall_cnt, 32'd0);
      @(posedge clk);
   endtask

   // Instruction-level model: class properties straight from the opcode map
   task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                            input logic zv, input bit abort);
      logic       legal, imm, rdsel;
      logic [2:0] aop;
      bit         is_mem, is_lw;
      legal = 1'b1; imm = 1'b0; rdsel = 1'b0; aop = 3'b000;
      case (op)
         OP_R, OP_SLT: begin aop = 3'b010; rdsel = 1'b1; end
         OP_ADDI: begin aop = 3'b011; imm = 1'b1; end
         OP_ANDI: begin aop = 3'b100; imm = 1'b1; end
         OP_XORI: begin aop = 3'b101; imm = 1'b1; end
         OP_SLTI: begin aop = 3'b110; imm = 1'b1; end
         OP_LW, OP_SW: begin aop = 3'b000; imm = 1'b1; end
         OP_BEQ: aop = 3'b001;
         OP_J:   aop = 3'b111;
         default: legal = 1'b0;
      endcase
      is_lw  = (op == OP_LW);
      is_mem = is_lw || (op == OP_SW);

      // FETCH: stalls then the accepted word
      for (int i = 0; i < fs; i++)
         cyc(3'd1, mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0), 1'b0, 1'($urandom), $urandom);
      cyc(3'd1, mk(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0), 1'b1, 1'($urandom),
          {op, 26'($urandom)});

      // DECODE
      if (op == OP_J) begin
         cyc(3'd2, mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0), 1'($urandom), 1'($urandom), $urandom);
         return;
      end
      if (!legal) begin
         cyc(3'd2, mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1), 1'($urandom), 1'($urandom), $urandom);
         return;
      end
      cyc(3'd2, 15'd0, 1'($urandom), 1'($urandom), $urandom);

      // EXEC
      if (op == OP_BEQ) begin
         cyc(3'd3, mk(zv, 2'b01, 0, 0, 0, 0, 0, 0, 0, aop, 1, 0), 1'($urandom), zv, $urandom);
         return;
      end
      cyc(3'd3, mk(0, 2'b00, 0, 0, 0, 0, 0, imm, 0, aop, 0, 0), 1'($urandom), 1'($urandom), $urandom);

      // MEM
      if (is_mem) begin
         for (int i = 0; i < ms; i++)
            cyc(3'd4, mk(0, 2'b00, 0, is_lw, !is_lw, 0, 0, 0, 0, 3'b000, 0, 0), 1'b0, 1'($urandom), $urandom);
         if (abort) begin
            do_reset(1);
            return;
         end
         cyc(3'd4, mk(0, 2'b00, 0, is_lw, !is_lw, 0, 0, 0, 0, 3'b000, !is_lw, 0), 1'b1, 1'($urandom), $urandom);
         if (!is_lw) return;
      end

      // WB
      cyc(3'd5, mk(0, 2'b00, 0, 0, 0, 1, rdsel, 0, is_lw, aop, 1, 0), 1'($urandom), 1'($urandom), $urandom);
   endtask

   initial begin
      logic [5:0] legal_ops [10];
      logic [5:0] op;
      legal_ops = '{OP_R, OP_ADDI, OP_ANDI, OP_XORI, OP_BEQ, OP_LW, OP_SW, OP_SLT, OP_SLTI, OP_J};
      chk_count  = 0;
      fail_count = 0;
      ret_m      = 0;
      stall_m    = 0;
      reset           = 1'b1;
      bus.mem_ready   = 1'b0;
      bus.zero        = 1'b0;
      bus.instr_rdata = 32'd0;

      do_reset(2);

      // Directed scenarios
      run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
      run_instr(OP_LW,   0, 2, 1'b0, 1'b0);
      run_instr(OP_BEQ,  0, 0, 1'b1, 1'b0);
      run_instr(OP_BEQ,  0, 0, 1'b0, 1'b0);
      run_instr(OP_J,    0, 0, 1'b0, 1'b0);
      run_instr(OP_ILL,  0, 0, 1'b0, 1'b0);
      run_instr(OP_R,    2, 0, 1'b0, 1'b0);
      run_instr(OP_SW,   1, 1, 1'b0, 1'b1);

      // Random instruction stream, roughly 1 in 8 illegal
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(7) == 0) op = 6'($urandom);
         else                        op = legal_ops[$urandom_range(9)];
         run_instr(op, ($urandom_range(3) == 0) ? $urandom_range(3) : 0,
                   ($urandom_range(2) == 0) ? $urandom_range(3) : 0,
                   1'($urandom), ($urandom_range(40) == 0));
         if ($urandom_range(60) == 0) do_reset(1 + $urandom_range(2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing controller for the RISCY datapath. It replaces the single-cycle decode path with a Moore state machine that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It stalls on a memory ready handshake and drives the register-file, ALU, memory and PC enables one phase at a time. It sits between the shared instruction/data memory port and the existing datapath muxes, and uses the processor's established opcode map and ALUOp encoding.

## Interface
- CNT_WIDTH, 32, width of performance counters (used only when CTRL_PERF_CNT_EN is defined)

- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- instr_rdata  in  32  memory read data; bits [31:26] are sampled as the opcode when ir_write=1
- mem_ready  in  1  memory port completed the current access this cycle
- zero  in  1  ALU zero flag, valid in EXECUTE
- pc_write  out  1  PC register enable
- pc_src  out  2  PC next source: 00 PC+4, 01 branch target, 10 jump target
- ir_write  out  1  instruction register and opcode latch enable
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- reg_dst  out  1  1 selects rd, 0 selects rt
- alu_src  out  1  1 selects immediate, 0 selects register B
- mem_to_reg  out  1  1 selects memory data for writeback
- alu_op  out  3  ALU opcode
- instr_done  out  1  one-cycle pulse on the final cycle of every legal instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unmapped opcode
- state  out  3  current state: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5
- retired_cnt  out  CNT_WIDTH  retired instruction count (CTRL_PERF_CNT_EN only)
- stall_cnt  out  CNT_WIDTH  memory stall cycle count (CTRL_PERF_CNT_EN only)

## Operation
- Opcode map: R-type 000000, addi 010000, andi 010001, xori 010010, beq 010011, lw 010101, sw 010110, slt 010111, slti 011000, j 011001. All other opcodes, including 010100, are illegal.
- ALUOp per class: lw/sw 000, beq 001, R-type/slt 010, addi 011, andi 100, xori 101, slti 110, j 111.
- Outputs are pure Moore functions of the state register and the latched opcode. Any output not listed for a state is 0.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, alu_op=000.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=00, opcode latched, next state DECODE.
  - If mem_ready=0: stay in FETCH.
- DECODE:
  - j: pc_write=1, pc_src=10, instr_done=1, next state FETCH.
  - Illegal opcode: illegal_op=1, next state FETCH; the PC has already advanced.
  - All others: next state EXEC.
- EXEC: alu_op per class. alu_src=1 for addi/andi/xori/slti/lw/sw, otherwise 0.
  - beq: pc_write=zero, pc_src=01, instr_done=1, next state FETCH.
  - lw/sw: next state MEM.
  - All others: next state WB.
- MEM:
  - lw: mem_read=1. If mem_ready=1, next state WB; else stay.
  - sw: mem_write=1. If mem_ready=1, instr_done=1 and next state FETCH; else stay.
- WB: reg_write=1, next state FETCH, instr_done=1.
  - reg_dst=1 for R-type/slt.
  - mem_to_reg=1 for lw.
  - alu_op held from EXEC.

## Timing
- reset high at a rising edge: state becomes INIT, opcode latch becomes 000000, counters clear. During INIT every output is 0.
- reset asserted mid-instruction aborts it; no write enable is asserted in the cycle after reset.
- Latency with mem_ready held high, counted from entry to FETCH:
  - j: 2 cycles
  - beq: 3 cycles
  - R-type/immediate: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
- Each cycle with mem_ready=0 in FETCH or MEM adds exactly one cycle.
- mem_ready is ignored in every state other than FETCH and MEM.
- mem_read and mem_write are never asserted together.
- instr_done and illegal_op are never asserted together.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - retired_cnt increments on every cycle with instr_done=1.
  - stall_cnt increments on every FETCH or MEM cycle with mem_ready=0.
  - Both counters wrap modulo 2^CNT_WIDTH and clear on reset.
- CTRL_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- reset for 2 cycles, then release: state=0 with all outputs 0 for one cycle, then state=1 with mem_read=1.
- addi (0x40000000 opcode 010000), mem_ready=1: states 1,2,3,5. In EXEC, alu_src=1 and alu_op=011. In WB, reg_write=1, reg_dst=0, and instr_done pulses in cycle 4.
- lw with mem_ready low for 2 cycles in MEM: MEM held 3 cycles with mem_read=1, then WB with mem_to_reg=1. Total 7 cycles; stall_cnt +2 with the macro defined.
- beq with zero=1 and then zero=0: EXEC shows pc_write=1, pc_src=01 in the first case and pc_write=0 in the second. Both return to FETCH after 3 cycles.
- j, then opcode 010100: j gives pc_write=1 and pc_src=10 in DECODE. 010100 gives an illegal_op pulse, no instr_done, and a return to FETCH.
- reset asserted during MEM of sw with mem_ready=0: next cycle state=0 and mem_write=0; retired_cnt=0.
